bank_req_sched: RTL and testbench
=================================

Name: bank_req_sched

Overview:
- Per-bank request scheduler between the core memory-request port and the cache banks.
- Accepts one multi-lane request batch, then issues at most one lane per bank per cycle until every lane has issued.
- Bank conflicts are serialized over multiple cycles. Each bank has its own round-robin pointer for fairness.
- Provides a batch-completion pulse and a bank-stall performance counter.

Parameters:
- NUM_REQS, 4, lanes per batch (≥2).
- NUM_BANKS, 2, number of banks (power of 2, ≤ NUM_REQS).
- ADDR_WIDTH, 30, word address width.
- DATA_WIDTH, 32, word data width.
- TAG_WIDTH, 8, per-lane tag width.
- BANK_ADDR_OFFSET, 0, LSB of the bank-select field in the word address.
- CTR_WIDTH, 44, stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  batch valid
- in_ready  out  1  batch accepted when in_valid && in_ready
- in_mask  in  NUM_REQS  active lanes
- in_rw  in  NUM_REQS  per-lane write enable
- in_addr  in  NUM_REQS*ADDR_WIDTH  per-lane word address
- in_byteen  in  NUM_REQS*DATA_WIDTH/8  per-lane byte enables
- in_data  in  NUM_REQS*DATA_WIDTH  per-lane write data
- in_tag  in  NUM_REQS*TAG_WIDTH  per-lane tag
- bank_valid  out  NUM_BANKS  per-bank request valid
- bank_ready  in  NUM_BANKS  per-bank accept
- bank_rw  out  NUM_BANKS  selected lane rw
- bank_addr  out  NUM_BANKS*ADDR_WIDTH  selected lane address
- bank_byteen  out  NUM_BANKS*DATA_WIDTH/8  selected lane byte enables
- bank_data  out  NUM_BANKS*DATA_WIDTH  selected lane data
- bank_tag  out  NUM_BANKS*TAG_WIDTH  selected lane tag
- bank_tid  out  NUM_BANKS*max(1,clog2(NUM_REQS))  selected lane index
- batch_done  out  1  one-cycle pulse: batch fully issued
- bank_stalls  out  CTR_WIDTH  stall counter

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - state = IDLE, pending = 0, all rr_ptr = 0.
  - bank_valid = 0, batch_done = 0, bank_stalls = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Bank id: bid[i] = in_addr[i][BANK_ADDR_OFFSET +: log2(NUM_BANKS)]; bid = 0 when NUM_BANKS = 1. Bank id is computed at accept and stored with the lane.
- Batch capture: on accept, in_mask and all lane fields are registered.
  - pending = in_mask.
  - state = ISSUE if in_mask ≠ 0; otherwise state stays IDLE and batch_done pulses in the next cycle.
- Issue latency: the first bank_valid appears in the cycle after accept. Nothing is combinational from in_* to bank_*.
- Lane selection per bank b, combinational on registered state:
  - Candidates are pending lanes with bid == b.
  - Grant the lowest index ≥ rr_ptr[b]; otherwise wrap and grant the lowest index overall.
  - bank_valid[b] = 1 iff at least one candidate exists.
  - bank_* fields are the granted lane's fields; bank_tid is the lane index.
  - When bank_valid[b] = 0, data outputs are don't-care.
- Fire: bank_valid[b] && bank_ready[b].
  - On fire, clear the granted pending bit and set rr_ptr[b] = (granted + 1) mod NUM_REQS.
  - rr_ptr moves only on fire.
- Stability: while bank_valid[b] && !bank_ready[b], the granted lane and all bank_* outputs for b hold unchanged.
- in_ready:
  - 1 in IDLE.
  - In ISSUE, 1 only in the cycle where every remaining pending lane fires. This is a combinational path from bank_ready.
  - A batch accepted that cycle loads directly (back-to-back); state stays ISSUE if the new mask ≠ 0.
- batch_done: registered; pulses 1 in the cycle after pending transitions to 0 (or after an empty-mask accept).
- bank_stalls: each ISSUE cycle adds popcount(pending lanes not fired this cycle). Covers both bank conflicts and ready backpressure. Wraps modulo 2^CTR_WIDTH.
- Reset mid-batch: pending lanes are dropped, no batch_done pulse is generated, and outputs return to their reset values.
- bank_ready while bank_valid = 0 is ignored.

Test Plan (NUM_REQS=4, NUM_BANKS=2, BANK_ADDR_OFFSET=0):
1. Conflicts, all ready: accept mask=1111, addrs 0,1,2,3 at T; bank_ready=11.
   - T+1: bank0 tid0, bank1 tid1.
   - T+2: bank0 tid2, bank1 tid3; in_ready=1.
   - T+3: batch_done=1. bank_stalls=2.
2. Round-robin order: following test 1 (ptr0=3, ptr1=0), send mask=1111, addrs 0,2,4,6 (all bank0).
   - bank0 issues tid 3,0,1,2 over four consecutive cycles; bank_valid[1]=0 throughout.
   - bank_stalls increases by 3+2+1=6.
3. Backpressure: single lane, mask=0001, addr 4; bank_ready[0]=0 for 3 cycles, then 1.
   - bank_valid[0] held with tid0 and addr 4 unchanged for 4 cycles.
   - bank_stalls +3; batch_done fires 1 cycle after the fire.
4. Empty batch: mask=0000 accepted at T.
   - No bank_valid; batch_done=1 at T+1; in_ready stays 1.
5. Back-to-back: during test 1's final issue cycle, present a new batch mask=0010, addr 5.
   - Accepted the same cycle; bank1 issues tid1 the next cycle; one batch_done pulse per batch.
6. Reset mid-batch: after one lane fires in test 1, assert reset for 1 cycle.
   - Next cycle: bank_valid=00, batch_done=0, bank_stalls=0, in_ready=1.

Source files
------------

// File: rtl/bank_req_sched.sv
// rtl/bank_req_sched.sv - per-bank round-robin scheduler for multi-lane memory request batches
//
// Accepts one batch of NUM_REQS lanes, then issues at most one lane per bank
// per cycle until every lane has been accepted by its bank.
//   clk, reset                  : clock, synchronous active-high reset
//   in_valid/in_ready           : batch handshake
//   in_mask, in_rw, in_addr,
//   in_byteen, in_data, in_tag  : per-lane request fields (packed, lane 0 in LSBs)
//   bank_valid/bank_ready       : per-bank handshake
//   bank_rw, bank_addr,
//   bank_byteen, bank_data,
//   bank_tag, bank_tid          : granted lane's fields and lane index per bank
//   batch_done                  : one-cycle pulse after a batch has fully issued
//   bank_stalls                 : running count of pending lanes left unissued per cycle
module bank_req_sched #(
    parameter int NUM_REQS         = 4,
    parameter int NUM_BANKS        = 2,
    parameter int ADDR_WIDTH       = 30,
    parameter int DATA_WIDTH       = 32,
    parameter int TAG_WIDTH        = 8,
    parameter int BANK_ADDR_OFFSET = 0,
    parameter int CTR_WIDTH        = 44,
    localparam int TID_W           = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int BE_W            = DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_REQS-1:0]             in_mask,
    input  logic [NUM_REQS-1:0]             in_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]  in_addr,
    input  logic [NUM_REQS*BE_W-1:0]        in_byteen,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]   in_tag,
    output logic [NUM_BANKS-1:0]            bank_valid,
    input  logic [NUM_BANKS-1:0]            bank_ready,
    output logic [NUM_BANKS-1:0]            bank_rw,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr,
    output logic [NUM_BANKS*BE_W-1:0]       bank_byteen,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_data,
    output logic [NUM_BANKS*TAG_WIDTH-1:0]  bank_tag,
    output logic [NUM_BANKS*TID_W-1:0]      bank_tid,
    output logic                            batch_done,
    output logic [CTR_WIDTH-1:0]            bank_stalls
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state;
    logic [NUM_REQS-1:0]     pending;
    logic [TID_W-1:0]        rr_ptr [NUM_BANKS];

    logic                    lane_rw   [NUM_REQS];
    logic [ADDR_WIDTH-1:0]   lane_addr [NUM_REQS];
    logic [BE_W-1:0]         lane_be   [NUM_REQS];
    logic [DATA_WIDTH-1:0]   lane_data [NUM_REQS];
    logic [TAG_WIDTH-1:0]    lane_tag  [NUM_REQS];
    logic [BANK_W-1:0]       lane_bid  [NUM_REQS];

    logic [NUM_BANKS-1:0]    grant_vld;
    logic [NUM_BANKS-1:0]    has_hi;
    logic [TID_W-1:0]        hi_idx    [NUM_BANKS];
    logic [TID_W-1:0]        lo_idx    [NUM_BANKS];
    logic [TID_W-1:0]        grant_idx [NUM_BANKS];
    logic [NUM_REQS-1:0]     fired;
    logic [NUM_REQS-1:0]     remaining;
    logic [CTR_WIDTH-1:0]    stall_inc;
    logic                    accept;

    // Round-robin pick per bank. Scanning downward leaves the lowest matching
    // index in each slot: hi_idx among lanes at/after the pointer, lo_idx overall.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            grant_vld[b] = 1'b0;
            has_hi[b]    = 1'b0;
            hi_idx[b]    = '0;
            lo_idx[b]    = '0;
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (pending[i] && (lane_bid[i] == BANK_W'(b))) begin
                    grant_vld[b] = 1'b1;
                    lo_idx[b]    = TID_W'(i);
                    if (TID_W'(i) >= rr_ptr[b]) begin
                        has_hi[b] = 1'b1;
                        hi_idx[b] = TID_W'(i);
                    end
                end
            end
            grant_idx[b] = has_hi[b] ? hi_idx[b] : lo_idx[b];
        end
    end

    always_comb begin
        fired = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_vld[b] && bank_ready[b]) begin
                fired[grant_idx[b]] = 1'b1;
            end
        end
        remaining = pending & ~fired;
        stall_inc = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            stall_inc = stall_inc + CTR_WIDTH'(remaining[i]);
        end
    end

    // In ISSUE a new batch may load only in the cycle the last pending lanes fire.
    assign in_ready = (state == IDLE) || (remaining == '0);
    assign accept   = in_valid && in_ready;

    always_comb begin
        bank_valid = grant_vld;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_rw[b]                           = lane_rw[grant_idx[b]];
            bank_addr[b*ADDR_WIDTH +: ADDR_WIDTH] = lane_addr[grant_idx[b]];
            bank_byteen[b*BE_W +: BE_W]           = lane_be[grant_idx[b]];
            bank_data[b*DATA_WIDTH +: DATA_WIDTH] = lane_data[grant_idx[b]];
            bank_tag[b*TAG_WIDTH +: TAG_WIDTH]    = lane_tag[grant_idx[b]];
            bank_tid[b*TID_W +: TID_W]            = grant_idx[b];
        end
    end

    // Lane payload and bank id, latched on accept; validity lives in pending.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                lane_rw[i]   <= in_rw[i];
                lane_addr[i] <= in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                lane_be[i]   <= in_byteen[i*BE_W +: BE_W];
                lane_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                lane_tag[i]  <= in_tag[i*TAG_WIDTH +: TAG_WIDTH];
                lane_bid[i]  <= (NUM_BANKS > 1)
                              ? in_addr[i*ADDR_WIDTH + BANK_ADDR_OFFSET +: BANK_W]
                              : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            batch_done  <= 1'b0;
            bank_stalls <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            batch_done <= 1'b0;
            if (state == ISSUE) begin
                pending     <= remaining;
                bank_stalls <= bank_stalls + stall_inc;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (grant_vld[b] && bank_ready[b]) begin
                        rr_ptr[b] <= (grant_idx[b] == TID_W'(NUM_REQS - 1))
                                   ? '0 : grant_idx[b] + 1'b1;
                    end
                end
                if (remaining == '0) begin
                    state      <= IDLE;
                    batch_done <= 1'b1;
                end
            end
            // Accept overrides the drain above so a back-to-back batch loads directly.
            if (accept) begin
                pending <= in_mask;
                if (in_mask != '0) begin
                    state <= ISSUE;
                end else begin
                    state      <= IDLE;
                    batch_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bank_req_sched.sv
// tb/tb_bank_req_sched.sv - self-checking bench for bank_req_sched with a lane-level reference model
module tb_bank_req_sched;

    localparam int NR  = 4;
    localparam int NB  = 2;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TGW = 8;
    localparam int OFF = 0;
    localparam int CW  = 44;
    localparam int TW  = 2;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NR-1:0]     in_mask;
    logic [NR-1:0]     in_rw;
    logic [NR*AW-1:0]  in_addr;
    logic [NR*BW-1:0]  in_byteen;
    logic [NR*DW-1:0]  in_data;
    logic [NR*TGW-1:0] in_tag;
    logic [NB-1:0]     bank_valid;
    logic [NB-1:0]     bank_ready;
    logic [NB-1:0]     bank_rw;
    logic [NB*AW-1:0]  bank_addr;
    logic [NB*BW-1:0]  bank_byteen;
    logic [NB*DW-1:0]  bank_data;
    logic [NB*TGW-1:0] bank_tag;
    logic [NB*TW-1:0]  bank_tid;
    logic              batch_done;
    logic [CW-1:0]     bank_stalls;

    bank_req_sched #(
        .NUM_REQS(NR), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TAG_WIDTH(TGW), .BANK_ADDR_OFFSET(OFF), .CTR_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_rw(in_rw),
        .in_addr(in_addr), .in_byteen(in_byteen), .in_data(in_data), .in_tag(in_tag),
        .bank_valid(bank_valid), .bank_ready(bank_ready), .bank_rw(bank_rw),
        .bank_addr(bank_addr), .bank_byteen(bank_byteen), .bank_data(bank_data),
        .bank_tag(bank_tag), .bank_tid(bank_tid),
        .batch_done(batch_done), .bank_stalls(bank_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a set of pending lanes with their fields and one pointer per bank.
    bit              m_pend [NR];
    logic [AW-1:0]   m_addr [NR];
    logic [TGW-1:0]  m_tag  [NR];
    logic [DW-1:0]   m_data [NR];
    logic [BW-1:0]   m_be   [NR];
    bit              m_rw   [NR];
    int              m_ptr  [NB];
    longint          m_stalls;
    bit              m_done;
    bit              m_acc;
    bit              m_nd;
    int              m_g    [NB];
    int              c_g;

    function automatic int m_bid(input int i);
        return int'((m_addr[i] >> OFF) % NB);
    endfunction

    function automatic int m_grant(input int b);
        for (int i = m_ptr[b]; i < NR; i++)
            if (m_pend[i] && m_bid(i) == b) return i;
        for (int i = 0; i < NR; i++)
            if (m_pend[i] && m_bid(i) == b) return i;
        return -1;
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < NR; i++)
            if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_left();
        int cnt = 0;
        for (int i = 0; i < NR; i++)
            if (m_pend[i] && !(bank_ready[m_bid(i)] && m_grant(m_bid(i)) == i)) cnt++;
        return cnt;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
            for (int b = 0; b < NB; b++) m_ptr[b] = 0;
            m_stalls = 0;
            m_done   = 1'b0;
        end else begin
            m_acc = in_valid && (!m_busy() || m_left() == 0);
            m_nd  = 1'b0;
            if (m_busy()) begin
                for (int b = 0; b < NB; b++) m_g[b] = m_grant(b);
                m_stalls = (m_stalls + m_left()) & ((64'd1 << CW) - 1);
                for (int b = 0; b < NB; b++) begin
                    if (m_g[b] >= 0 && bank_ready[b]) begin
                        m_pend[m_g[b]] = 1'b0;
                        m_ptr[b] = (m_g[b] + 1) % NR;
                    end
                end
                if (!m_busy()) m_nd = 1'b1;
            end
            if (m_acc) begin
                for (int i = 0; i < NR; i++) begin
                    m_pend[i] = in_mask[i];
                    m_addr[i] = in_addr[i*AW +: AW];
                    m_tag[i]  = in_tag[i*TGW +: TGW];
                    m_data[i] = in_data[i*DW +: DW];
                    m_be[i]   = in_byteen[i*BW +: BW];
                    m_rw[i]   = in_rw[i];
                end
                if (in_mask == '0) m_nd = 1'b1;
            end
            m_done = m_nd;
        end
    end

    always @(negedge clk) begin
        #2;
        if (check_en) begin
            check("in_ready", in_ready, (!m_busy() || m_left() == 0));
            check("batch_done", batch_done, m_done);
            check("bank_stalls", bank_stalls, m_stalls);
            for (int b = 0; b < NB; b++) begin
                c_g = m_grant(b);
                check($sformatf("bank_valid[%0d]", b), bank_valid[b], c_g >= 0);
                if (c_g >= 0) begin
                    check($sformatf("bank_tid[%0d]", b), bank_tid[b*TW +: TW], c_g);
                    check($sformatf("bank_addr[%0d]", b), bank_addr[b*AW +: AW], m_addr[c_g]);
                    check($sformatf("bank_tag[%0d]", b), bank_tag[b*TGW +: TGW], m_tag[c_g]);
                    check($sformatf("bank_data[%0d]", b), bank_data[b*DW +: DW], m_data[c_g]);
                    check($sformatf("bank_byteen[%0d]", b), bank_byteen[b*BW +: BW], m_be[c_g]);
                    check($sformatf("bank_rw[%0d]", b), bank_rw[b], m_rw[c_g]);
                end
            end
        end
    end

    task automatic set_batch(input logic [NR-1:0] mask, input int a0, input int a1,
                             input int a2, input int a3);
        int a [NR];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        in_valid  = 1'b1;
        in_mask   = mask;
        in_rw     = NR'($urandom);
        in_byteen = (NR*BW)'($urandom);
        for (int i = 0; i < NR; i++) begin
            in_addr[i*AW +: AW]   = AW'(a[i]);
            in_data[i*DW +: DW]   = $urandom;
            in_tag[i*TGW +: TGW]  = TGW'($urandom);
        end
    endtask

    int t2 [4];

    initial begin
        t2 = '{3, 0, 1, 2};
        reset = 1'b1; in_valid = 1'b0; bank_ready = '0;
        in_mask = '0; in_rw = '0; in_addr = '0; in_byteen = '0; in_data = '0; in_tag = '0;
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk); reset = 1'b0;
        #3;
        check("rst in_ready", in_ready, 1);
        check("rst bank_valid", bank_valid, 0);
        check("rst batch_done", batch_done, 0);
        check("rst bank_stalls", bank_stalls, 0);

        // conflicts, all ready
        @(negedge clk); set_batch(4'b1111, 0, 1, 2, 3); bank_ready = 2'b11;
        @(negedge clk); in_valid = 1'b0; #3;
        check("t1 valid", bank_valid, 2'b11);
        check("t1 tid0 c1", bank_tid[1:0], 0);
        check("t1 tid1 c1", bank_tid[3:2], 1);
        check("t1 in_ready c1", in_ready, 0);
        @(negedge clk); #3;
        check("t1 tid0 c2", bank_tid[1:0], 2);
        check("t1 tid1 c2", bank_tid[3:2], 3);
        check("t1 in_ready c2", in_ready, 1);
        @(negedge clk); set_batch(4'b1111, 0, 2, 4, 6); #3;
        check("t1 done", batch_done, 1);
        check("t1 stalls", bank_stalls, 2);

        // round-robin order within one bank
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); in_valid = 1'b0; #3;
            check($sformatf("t2 valid c%0d", k), bank_valid, 2'b01);
            check($sformatf("t2 tid c%0d", k), bank_tid[1:0], t2[k]);
        end
        @(negedge clk); set_batch(4'b0001, 4, 0, 0, 0); bank_ready = 2'b10; #3;
        check("t2 done", batch_done, 1);
        check("t2 stalls", bank_stalls, 8);

        // backpressure holds the request
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); in_valid = 1'b0; bank_ready = (k == 3) ? 2'b11 : 2'b10; #3;
            check($sformatf("t3 valid c%0d", k), bank_valid, 2'b01);
            check($sformatf("t3 tid c%0d", k), bank_tid[1:0], 0);
            check($sformatf("t3 addr c%0d", k), bank_addr[AW-1:0], 4);
        end
        @(negedge clk); set_batch(4'b0000, 0, 0, 0, 0); #3;
        check("t3 done", batch_done, 1);
        check("t3 stalls", bank_stalls, 11);

        // empty batch
        @(negedge clk); in_valid = 1'b0; #3;
        check("t4 valid", bank_valid, 0);
        check("t4 done", batch_done, 1);
        check("t4 in_ready", in_ready, 1);

        // back-to-back batches
        @(negedge clk); set_batch(4'b1111, 0, 1, 2, 3); bank_ready = 2'b11;
        @(negedge clk); in_valid = 1'b0; #3;
        check("t5 tid0 c1", bank_tid[1:0], 2);
        check("t5 tid1 c1", bank_tid[3:2], 1);
        @(negedge clk); set_batch(4'b0010, 0, 5, 0, 0); #3;
        check("t5 in_ready c2", in_ready, 1);
        @(negedge clk); in_valid = 1'b0; #3;
        check("t5 next valid", bank_valid, 2'b10);
        check("t5 next tid1", bank_tid[3:2], 1);
        check("t5 done old", batch_done, 1);
        @(negedge clk); #3;
        check("t5 done new", batch_done, 1);
        @(negedge clk); #3;
        check("t5 done clear", batch_done, 0);

        // reset mid-batch
        @(negedge clk); set_batch(4'b1111, 0, 1, 2, 3); bank_ready = 2'b01;
        @(negedge clk); in_valid = 1'b0; #3;
        check("t6 valid", bank_valid, 2'b11);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #3;
        check("t6 valid", bank_valid, 0);
        check("t6 done", batch_done, 0);
        check("t6 stalls", bank_stalls, 0);
        check("t6 in_ready", in_ready, 1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 299) == 0);
            bank_ready = NB'($urandom);
            if ($urandom_range(0, 2) != 0)
                set_batch(NR'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 15), $urandom_range(0, 15));
            else
                in_valid = 1'b0;
        end
        @(negedge clk); reset = 1'b0; in_valid = 1'b0;
        @(negedge clk); #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
